// File: rtl/fpga_robots_game_defs.sv
// Shared tile-map constants, arbiter state encoding and wait-counter helper.
package fpga_robots_game_defs;

  localparam int unsigned TM_AW = 13;
  localparam int unsigned TM_DW = 8;
  localparam int unsigned TMA_CNT_W = 2;

  typedef enum logic [1:0] {
    TMA_IDLE  = 2'd0,
    TMA_ISSUE = 2'd1,
    TMA_WAIT  = 2'd2,
    TMA_ACK   = 2'd3
  } tma_state_e;

  // WAIT lasts rd_lat cycles, so the down-counter starts at rd_lat-1.
  function automatic logic [TMA_CNT_W-1:0] tma_wait_init(input int unsigned rd_lat);
    return TMA_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/fpga_robots_game_tm_pick.sv
// Two-way grant selector; round-robin when FPGA_ROBOTS_GAME_TM_ARB_RR_EN is
// defined, otherwise requester 0 has fixed priority.
module fpga_robots_game_tm_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef FPGA_ROBOTS_GAME_TM_ARB_RR_EN
  // On contention the requester not granted most recently wins.
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = {req1, req0};
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = 2'b00;
    if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/fpga_robots_game_tm_arbiter.sv
// Shares the video tile-map port between game logic (0) and host/debug (1).
// Round-robin arbitration is built when FPGA_ROBOTS_GAME_TM_ARB_RR_EN is defined.
module fpga_robots_game_tm_arbiter
  import fpga_robots_game_defs::*;
#(
  parameter int unsigned AW     = TM_AW,
  parameter int unsigned DW     = TM_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rq0_req,
  input  logic [AW-1:0] rq0_adr,
  input  logic          rq0_wen,
  input  logic [DW-1:0] rq0_wdt,
  output logic          rq0_ack,
  output logic [DW-1:0] rq0_rdt,
  input  logic          rq1_req,
  input  logic [AW-1:0] rq1_adr,
  input  logic          rq1_wen,
  input  logic [DW-1:0] rq1_wdt,
  output logic          rq1_ack,
  output logic [DW-1:0] rq1_rdt,
  output logic [AW-1:0] tm_adr,
  output logic [DW-1:0] tm_wrt,
  output logic          tm_wen,
  input  logic [DW-1:0] tm_red
);

  tma_state_e           state;
  logic [TMA_CNT_W-1:0] wait_cnt;
  logic                 sel_q;
  logic                 last_c;
  logic [1:0]           gnt_c;

  fpga_robots_game_tm_pick u_pick (
    .req0 (rq0_req),
    .req1 (rq1_req),
    .last (last_c),
    .gnt  (gnt_c)
  );

`ifdef FPGA_ROBOTS_GAME_TM_ARB_RR_EN
  logic last_q;

  // Last-granted requester; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state == TMA_IDLE && gnt_c != 2'b00) begin
      last_q <= gnt_c[1];
    end
  end

  assign last_c = last_q;
`else
  assign last_c = 1'b1;
`endif

  // Transaction sequencer: IDLE -> ISSUE -> WAIT x RD_LAT -> ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TMA_IDLE;
      wait_cnt <= '0;
      sel_q    <= 1'b0;
      tm_adr   <= '0;
      tm_wrt   <= '0;
      tm_wen   <= 1'b0;
      rq0_ack  <= 1'b0;
      rq1_ack  <= 1'b0;
      rq0_rdt  <= '0;
      rq1_rdt  <= '0;
    end else begin
      rq0_ack <= 1'b0;
      rq1_ack <= 1'b0;
      case (state)
        TMA_IDLE: begin
          if (gnt_c != 2'b00) begin
            sel_q <= gnt_c[1];
            if (gnt_c[1]) begin
              tm_adr <= rq1_adr;
              tm_wrt <= rq1_wdt;
              tm_wen <= rq1_wen;
            end else begin
              tm_adr <= rq0_adr;
              tm_wrt <= rq0_wdt;
              tm_wen <= rq0_wen;
            end
            state <= TMA_ISSUE;
          end
        end
        TMA_ISSUE: begin
          tm_wen   <= 1'b0;
          wait_cnt <= tma_wait_init(RD_LAT);
          state    <= TMA_WAIT;
        end
        TMA_WAIT: begin
          if (wait_cnt == '0) begin
            if (sel_q) begin
              rq1_rdt <= tm_red;
              rq1_ack <= 1'b1;
            end else begin
              rq0_rdt <= tm_red;
              rq0_ack <= 1'b1;
            end
            state <= TMA_ACK;
          end else begin
            wait_cnt <= wait_cnt - TMA_CNT_W'(1);
          end
        end
        TMA_ACK: begin
          state <= TMA_IDLE;
        end
        default: begin
          state <= TMA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_tm_arbiter.sv
// Scoreboard bench for the tile-map arbiter: random and directed transactions,
// an in-bench tile-map memory and a reference image of its contents.
module tb_fpga_robots_game_tm_arbiter #(
  parameter int unsigned RD_LAT = 1
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  typedef struct {
    logic          wen;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic [DW-1:0] exp_rdt;
    int            ack_cyc;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rq0_req = 1'b0, rq1_req = 1'b0;
  logic [AW-1:0] rq0_adr = '0, rq1_adr = '0;
  logic          rq0_wen = 1'b0, rq1_wen = 1'b0;
  logic [DW-1:0] rq0_wdt = '0, rq1_wdt = '0;
  logic          rq0_ack, rq1_ack;
  logic [DW-1:0] rq0_rdt, rq1_rdt;
  logic [AW-1:0] tm_adr;
  logic [DW-1:0] tm_wrt;
  logic          tm_wen;
  logic [DW-1:0] tm_red;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_any_ack = -1;
  bit gap_exact = 1'b0;
  int lack [2] = '{-100, -100};
  bit issued_w [2] = '{1'b0, 1'b0};

  txn_t q0[$];
  txn_t q1[$];
  int   ord_q[$];

  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] pipe    [RD_LAT];

  fpga_robots_game_tm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .rq0_req (rq0_req),
    .rq0_adr (rq0_adr),
    .rq0_wen (rq0_wen),
    .rq0_wdt (rq0_wdt),
    .rq0_ack (rq0_ack),
    .rq0_rdt (rq0_rdt),
    .rq1_req (rq1_req),
    .rq1_adr (rq1_adr),
    .rq1_wen (rq1_wen),
    .rq1_wdt (rq1_wdt),
    .rq1_ack (rq1_ack),
    .rq1_rdt (rq1_rdt),
    .tm_adr  (tm_adr),
    .tm_wrt  (tm_wrt),
    .tm_wen  (tm_wen),
    .tm_red  (tm_red)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tile-map memory: samples tm_adr each edge, data appears RD_LAT cycles later.
  always @(posedge clk) begin
    if (tm_wen) mem[tm_adr] <= tm_wrt;
    pipe[0] <= mem[tm_adr];
    for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign tm_red = pipe[RD_LAT-1];

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h1FFF) return 8'h3C;
    return DW'(a ^ (a >> 5) ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Spec-level arbitration order when both requesters keep requesting.
  function automatic void build_order(input int n0, input int n1);
    int last = 1;
    int id;
    while (n0 > 0 || n1 > 0) begin
      if (n0 > 0 && n1 > 0) begin
`ifdef FPGA_ROBOTS_GAME_TM_ARB_RR_EN
        id = (last == 1) ? 0 : 1;
`else
        id = 0;
`endif
      end else begin
        id = (n0 > 0) ? 0 : 1;
      end
      ord_q.push_back(id);
      if (id == 0) n0--; else n1--;
      last = id;
    end
  endfunction

  task automatic on_ack(input int r, input logic [DW-1:0] rdt);
    txn_t t;
    if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
      chk($sformatf("spurious_ack%0d", r), 1, 0);
      return;
    end
    t = (r == 0) ? q0.pop_front() : q1.pop_front();
    if (!t.wen) chk($sformatf("rdt%0d", r), rdt, t.exp_rdt);
    else        chk($sformatf("write_issued%0d", r), issued_w[r], 1);
    issued_w[r] = 1'b0;
    if (t.ack_cyc >= 0) chk($sformatf("ack_cyc%0d", r), cyc, t.ack_cyc);
    if (last_any_ack >= 0) begin
      if (gap_exact) chk("ack_gap", cyc - last_any_ack, RD_LAT + 3);
      else           chk("ack_gap_min", (cyc - last_any_ack) >= int'(RD_LAT + 3), 1);
    end
    last_any_ack = cyc;
    if (ord_q.size() > 0) chk("grant_order", r, ord_q.pop_front());
  endtask

  task automatic on_wen();
    int r;
    txn_t t;
    r = int'(tm_adr[AW-1]);
    if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
      chk("spurious_tm_wen", 1, 0);
      return;
    end
    t = (r == 0) ? q0[0] : q1[0];
    chk("tm_wen_once", issued_w[r], 0);
    issued_w[r] = 1'b1;
    chk("tm_wen_on_write", t.wen, 1);
    chk("tm_adr", tm_adr, t.adr);
    chk("tm_wrt", tm_wrt, t.wdt);
    if (t.ack_cyc >= 0) chk("tm_wen_cyc", cyc, t.ack_cyc - 1 - int'(RD_LAT));
  endtask

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rq0_ack && rq1_ack) chk("dual_ack", 1, 0);
      if (rq0_ack) on_ack(0, rq0_rdt);
      if (rq1_ack) on_ack(1, rq1_rdt);
      if (tm_wen) on_wen();
    end
  end

  task automatic drive(input int r, input logic req, input logic wen,
                       input logic [AW-1:0] adr, input logic [DW-1:0] wdt);
    if (r == 0) begin
      rq0_req = req; rq0_wen = wen; rq0_adr = adr; rq0_wdt = wdt;
    end else begin
      rq1_req = req; rq1_wen = wen; rq1_adr = adr; rq1_wdt = wdt;
    end
  endtask

  // Issue one transaction at the current falling edge and wait for its ack.
  task automatic do_txn(input int r, input logic wen, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wdt, input bit chk_lat);
    txn_t t;
    bit got = 1'b0;
    int start;
    t.wen = wen; t.adr = adr; t.wdt = wdt; t.exp_rdt = ref_mem[adr];
    start = (cyc > lack[r]) ? cyc : lack[r] + 1;
    t.ack_cyc = chk_lat ? start + 2 + int'(RD_LAT) : -1;
    if (wen) ref_mem[adr] = wdt;
    if (r == 0) q0.push_back(t); else q1.push_back(t);
    drive(r, 1'b1, wen, adr, wdt);
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? rq0_ack : rq1_ack;
      // Once granted the requester may change its inputs freely.
      if (!got && chk_lat && cyc > start)
        drive(r, 1'b1, ~wen, AW'($urandom), DW'($urandom));
    end
    if (!got) chk($sformatf("ack_timeout%0d", r), 0, 1);
    lack[r] = cyc;
    drive(r, 1'b0, 1'b0, AW'($urandom), DW'($urandom));
  endtask

  task automatic run_req(input int r, input int n, input int gapmax, input bit chk_lat);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      a = {r[0], 12'($urandom_range(0, 15))};
      do_txn(r, 1'($urandom), a, DW'($urandom), chk_lat);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    q0.delete(); q1.delete(); ord_q.delete();
    issued_w[0] = 1'b0; issued_w[1] = 1'b0;
    last_any_ack = -1;
    repeat (3) @(negedge clk);
    chk("rst_tm_adr", tm_adr, 0);
    chk("rst_tm_wrt", tm_wrt, 0);
    chk("rst_tm_wen", tm_wen, 0);
    chk("rst_acks", {rq0_ack, rq1_ack}, 0);
    chk("rst_rdt0", rq0_rdt, 0);
    chk("rst_rdt1", rq1_rdt, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    @(negedge clk);
    apply_reset();
    repeat (5) begin
      @(negedge clk);
      chk("idle_tm_wen", tm_wen, 0);
    end

    // Directed: write from 0, read it back, read 0x1FFF from 1.
    do_txn(0, 1'b1, 13'h0123, 8'hA5, 1'b1);
    do_txn(0, 1'b0, 13'h0123, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    do_txn(1, 1'b0, 13'h1FFF, 8'h00, 1'b1);

    // Back-to-back from a single requester.
    run_req(1, 4, 0, 1'b1);

    // Reset during WAIT: no ack, pointer back to requester 0.
    do_txn(0, 1'b0, 13'h0007, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 1'b0, 13'h0009, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    last_any_ack = -1;
    @(negedge clk);
    chk("midrst_tm_wen", tm_wen, 0);
    chk("midrst_acks", {rq0_ack, rq1_ack}, 0);
    rst = 1'b0;
    repeat (RD_LAT + 4) begin
      @(negedge clk);
      chk("midrst_no_ack", {rq0_ack, rq1_ack}, 0);
    end
    build_order(1, 1);
    fork
      do_txn(0, 1'b0, 13'h0002, 8'h00, 1'b0);
      do_txn(1, 1'b0, 13'h1003, 8'h00, 1'b0);
    join

    // Continuous contention from both requesters.
    apply_reset();
    build_order(4, 4);
    gap_exact = 1'b1;
    fork
      run_req(0, 4, 0, 1'b0);
      run_req(1, 4, 0, 1'b0);
    join
    gap_exact = 1'b0;

    // Random mix.
    fork
      run_req(0, 25, 3, 1'b0);
      run_req(1, 25, 3, 1'b0);
    join

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    chk("order_drained", ord_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpga_robots_game_tm_arbiter.md
# fpga_robots_game_tm_arbiter

Arbiter and sequencer for the single tile-map memory port owned by the video generator (`tm_adr` / `tm_red` / `tm_wrt` / `tm_wen`). It shares that port between two requesters:

- requester 0: game-play logic;
- requester 1: serial host / debug command interface.

Each transaction runs through a fixed, non-pipelined state sequence. The block sits in the top level, between the requesters and the video module's tile-map port.

## Interface
Parameters:
- `AW`, 13, tile-map address width.
- `DW`, 8, tile-map data width.
- `RD_LAT`, 1, tile-map read latency in cycles; legal range 1..3.

Ports:
- `clk`  in  1  system clock (~65 MHz pixel clock); the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rq0_req`  in  1  requester 0 transaction request.
- `rq0_adr`  in  AW  requester 0 address.
- `rq0_wen`  in  1  requester 0 write (1) / read (0).
- `rq0_wdt`  in  DW  requester 0 write data.
- `rq0_ack`  out  1  requester 0 completion pulse.
- `rq0_rdt`  out  DW  requester 0 read data; valid while `rq0_ack`=1.
- `rq1_req`, `rq1_adr`, `rq1_wen`, `rq1_wdt`, `rq1_ack`, `rq1_rdt`: same as requester 0, for requester 1.
- `tm_adr`  out  AW  tile-map address, registered.
- `tm_wrt`  out  DW  tile-map write data, registered.
- `tm_wen`  out  1  tile-map write enable, registered.
- `tm_red`  in  DW  tile-map read data, from the video module.

## Operation
- **States:**
  - IDLE → ISSUE when any request is present.
  - ISSUE → WAIT.
  - WAIT stays for `RD_LAT` cycles (down-counter, 2 bits), then → ACK.
  - ACK → IDLE.
- **Request sampling:** requests are sampled only in IDLE. Granted inputs (`adr`, `wen`, `wdt`) are latched at the grant edge, so the requester may change them after the grant.
- **ISSUE:**
  - `tm_adr` and `tm_wrt` carry the latched values.
  - `tm_wen` = the latched `wen`, for exactly this one cycle.
- **WAIT and ACK:**
  - `tm_wen`=0.
  - `tm_adr` holds its value.
- **Capture:** on the last WAIT edge, `tm_red` is captured into the granted requester's `rdt` register and that requester's `ack` is set. For writes the captured data is don't-care but `ack` is still given.
- **ACK:** `ack` is high for exactly one cycle. `rdt` holds its value until that requester's next capture.
- **Requester rule:** `req` must be low in the cycle after `ack`. A `req` seen high in the following IDLE is a new transaction.
- **Arbitration in IDLE:**
  - Single requester: it is granted.
  - Both requesting: resolved per Configuration.
- **Reset, any state:**
  - Next state IDLE.
  - `tm_wen`=0 on the next cycle.
  - No `ack` is issued for an aborted transaction.
  - Round-robin pointer returns to "last granted = 1", so requester 0 wins first.

## Timing
- **Reset values:** `tm_adr`=0, `tm_wrt`=0, `tm_wen`=0, `rq0_ack`=`rq1_ack`=0, `rq0_rdt`=`rq1_rdt`=0, state IDLE.
- **Cycle sequence,** with the request seen in IDLE at cycle T:
  - Cycles T+2 .. T+1+`RD_LAT`: WAIT.
  - Cycle T+2+`RD_LAT`: `ack`.
  - Cycle T+3+`RD_LAT`: IDLE.
- **Read path:** the memory samples `tm_adr` at the end of T+1, so `tm_red` is valid in cycle T+1+`RD_LAT`.
- **Latency and throughput:**
  - Request-to-`ack` latency: `RD_LAT`+2 cycles.
  - Throughput: one transaction per `RD_LAT`+3 cycles (4 cycles at default).
- **Starvation:** a requester never waits more than one transaction while round-robin is enabled.

## Configuration
Macro: `FPGA_ROBOTS_GAME_TM_ARB_RR_EN`.
- **Defined:** round-robin. On a simultaneous request, the requester not granted most recently wins. A 1-bit last-grant register updates on every grant.
- **Undefined:** fixed priority; requester 0 always wins. The last-grant register is not built.

## Structure
- **Shared package/include `fpga_robots_game_defs`:**
  - `TM_AW`=13 and `TM_DW`=8.
  - State encoding constants `TMA_IDLE`, `TMA_ISSUE`, `TMA_WAIT`, `TMA_ACK`.
- **Sub-module `fpga_robots_game_tm_pick`:** combinational two-way grant selector. Inputs: `req0`, `req1`, `last`. Output: one-hot `gnt`. Its round-robin path is compiled under the macro.

## Test plan
- **Reset state:** assert `rst` 3 cycles → all outputs 0. Afterwards, idle with no requests → `tm_wen` stays 0.
- **Write from requester 0:** `adr`=0x0123, `wdt`=0xA5, `wen`=1 → `tm_adr`=0x0123, `tm_wrt`=0xA5, `tm_wen`=1 in T+1 only; `rq0_ack` in T+3.
- **Read from requester 1:** `adr`=0x1FFF, memory model returns 0x3C → `rq1_rdt`=0x3C with `rq1_ack` at T+3, `RD_LAT`=1. Repeat with `RD_LAT`=3 → `ack` at T+5.
- **Contention, both requesting continuously:**
  - With the macro defined → grants alternate 0,1,0,1, one every 4 cycles.
  - With the macro undefined → requester 0 always granted.
- **Reset mid-transaction:** assert `rst` during WAIT → no `ack`; `tm_wen`=0. The first grant after reset goes to requester 0 when both request.
- **Back-to-back:** a requester drops `req` after `ack` and re-raises it in the next IDLE → a second transaction starts immediately; no duplicate `ack`.
